shift_seq_ctrl: RTL and testbench

Sequencing controller for the serial shift datapath. It accepts a parallel word through a valid/ready handshake and owns the internal shift register. It shifts the word out one bit per clock with frame strobes, then enforces a programmable inter-frame gap. It sits between a word-level producer and a bit-serial consumer.

---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_seq_datapath.sv | 59 +++++
 rtl/shift_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the serial shift sequencer.
//   state_t    : controller states (idle, shifting a frame, inter-frame gap)
//   clog2      : ceil(log2(n)) for counter sizing
//   cnt_w      : counter width for a count range of n (never below 1 bit)
//   WIDTH_MAX / GAP_MAX : legal parameter ceilings
package shift_seq_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int GAP_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_seq_datapath.sv
// Loadable WIDTH-bit shift register with direction select plus bit counter.
//   load      : capture load_data / lsb_first, present the first bit
//   shift     : advance to the next bit, bump bit_cnt
//   clear     : drop the word, ser_out and bit_cnt to zero (wins over load/shift)
//   ser_out   : registered current serial bit
//   bit_cnt   : index of the bit currently on ser_out
//   last      : bit_cnt is at WIDTH-1
module shift_seq_datapath
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             lsb_first,
  output logic             ser_out,
  output logic [CW-1:0]    bit_cnt,
  output logic             last
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_nxt;
  logic             lsb_q;

  // The emitting end of the register always holds the bit that goes out next,
  // so ser_out can be a plain flop loaded from that end.
  always_comb sr_nxt = lsb_q ? (sr_q >> 1) : (sr_q << 1);

  assign last = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= '0;
      lsb_q   <= 1'b0;
      ser_out <= 1'b0;
      bit_cnt <= '0;
    end else if (clear) begin
      sr_q    <= '0;
      lsb_q   <= 1'b0;
      ser_out <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      sr_q    <= load_data;
      lsb_q   <= lsb_first;
      ser_out <= lsb_first ? load_data[0] : load_data[WIDTH-1];
      bit_cnt <= '0;
    end else if (shift) begin
      sr_q    <= sr_nxt;
      ser_out <= lsb_q ? sr_nxt[0] : sr_nxt[WIDTH-1];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the serial shift datapath. Accepts a word over
// load_valid/load_ready, shifts it out one bit per clock with frame strobes,
// then holds off GAP idle cycles before the next accept.
//   load_valid/load_data/lsb_first : producer side (order sampled on accept)
//   abort       : synchronous cancel; also blocks an accept in idle
//   load_ready  : combinational, idle and no abort
//   ser_out/ser_valid/frame_start/frame_end/busy : registered serial side
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             lsb_first,
  input  logic             abort,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || GAP < 0 || GAP > GAP_MAX) begin : g_bad_param
    $error("shift_seq_ctrl: WIDTH or GAP out of range");
  end

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = clog2(GAP_MAX + 1);

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   bit_cnt;
  logic            last;
  logic            accept;
  logic            shift;
  logic            clear;
  logic            fe_d;

  assign load_ready = (state_q == ST_IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) state_d = ST_IDLE;
        else if (last) begin
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (abort || gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) gap_d = '0;
  end

  // Datapath control follows the next state: anything that leaves SHIFT
  // clears the bit, which also keeps ser_out at 0 in idle and gap.
  assign shift = (state_q == ST_SHIFT) && (state_d == ST_SHIFT);
  assign clear = (state_d != ST_SHIFT);

  // The next cycle shows the last bit either straight from an accept
  // (single-bit frames) or when the counter advances onto WIDTH-1.
  assign fe_d = accept ? (WIDTH == 1) : (shift && (int'(bit_cnt) == WIDTH - 2));

  shift_seq_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .shift     (shift),
    .clear     (clear),
    .load_data (load_data),
    .lsb_first (lsb_first),
    .ser_out   (ser_out),
    .bit_cnt   (bit_cnt),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ser_valid   <= (state_d == ST_SHIFT);
      frame_start <= accept;
      frame_end   <= fe_d;
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: three instances (W4/G0, W4/G3, W1/G0) share one
// input stream; each is compared every cycle against a frame-level model,
// with a few directed constant checks layered on top.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lv = 1'b0;
  logic       lsbf = 1'b0;
  logic       ab = 1'b0;
  logic [3:0] ld = 4'h0;

  wire [2:0] lr, so, sv, fs, fe, bz;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(4), .GAP(0)) u_w4g0 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv), .load_data(ld), .lsb_first(lsbf),
    .abort(ab), .load_ready(lr[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));

  shift_seq_ctrl #(.WIDTH(4), .GAP(3)) u_w4g3 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv), .load_data(ld), .lsb_first(lsbf),
    .abort(ab), .load_ready(lr[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));

  shift_seq_ctrl #(.WIDTH(1), .GAP(0)) u_w1g0 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv), .load_data(ld[0:0]), .lsb_first(lsbf),
    .abort(ab), .load_ready(lr[2]), .ser_out(so[2]), .ser_valid(sv[2]),
    .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

  // Frame-level model: a frame is "bit k of word is on the wire", followed by
  // a count of remaining gap cycles.
  typedef struct {
    bit         active;
    int         k;
    int         gap_left;
    logic [3:0] word;
    bit         lsb;
  } mdl_t;

  mdl_t m [3];
  int   mw [3] = '{4, 4, 1};
  int   mg [3] = '{0, 3, 0};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0b expected=%0b", tag, i, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_idle(input int i);
    return !m[i].active && (m[i].gap_left == 0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].active = 0; m[i].k = 0; m[i].gap_left = 0; m[i].word = 4'h0; m[i].lsb = 0;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 3; i++) begin
      if (m[i].active) begin
        if (ab) m[i].active = 0;
        else if (m[i].k == mw[i] - 1) begin
          m[i].active = 0;
          m[i].gap_left = mg[i];
        end else m[i].k++;
      end else if (m[i].gap_left > 0) begin
        if (ab) m[i].gap_left = 0;
        else m[i].gap_left--;
      end else if (lv && !ab) begin
        m[i].active = 1; m[i].k = 0; m[i].word = ld; m[i].lsb = lsbf;
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 3; i++) begin
      logic e;
      int   idx;
      e = 1'b0;
      if (m[i].active) begin
        idx = m[i].lsb ? m[i].k : (mw[i] - 1 - m[i].k);
        e = m[i].word[idx];
      end
      chk("ser_valid",   i, sv[i], m[i].active);
      chk("ser_out",     i, so[i], e);
      chk("frame_start", i, fs[i], m[i].active && m[i].k == 0);
      chk("frame_end",   i, fe[i], m[i].active && m[i].k == mw[i] - 1);
      chk("busy",        i, bz[i], !m_idle(i));
    end
  endtask

  task automatic check_ready();
    for (int i = 0; i < 3; i++) chk("load_ready", i, lr[i], m_idle(i) && !ab);
  endtask

  task automatic tick(input logic v, input logic [3:0] d, input logic l, input logic a);
    lv = v; ld = d; lsbf = l; ab = a;
    #1;
    check_ready();
    @(posedge clk);
    m_step();
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] seq;
    int         t_first, t_second;

    // reset state
    m_reset();
    #2;
    check_outs();
    check_ready();
    #10 reset_n = 1'b1;

    // 1: MSB first, 1011
    tick(1'b1, 4'hB, 1'b0, 1'b0);
    seq[3] = so[0];
    chk("t1_start", 0, fs[0], 1'b1);
    for (int j = 2; j >= 0; j--) begin
      tick(1'b0, 4'h0, 1'b0, 1'b0);
      seq[j] = so[0];
    end
    chk("t1_end", 0, fe[0], 1'b1);
    chki("t1_seq", int'(seq), 11);
    tick(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t1_ready", 0, lr[0], 1'b1);
    idle(4);

    // 2: LSB first, data changed mid-frame
    tick(1'b1, 4'hB, 1'b1, 1'b0);
    seq[0] = so[0];
    for (int j = 1; j < 4; j++) begin
      tick(1'b0, 4'h4, 1'b0, 1'b0);
      seq[j] = so[0];
    end
    chki("t2_seq", int'(seq), 11);
    idle(4);

    // 3: GAP=3 spacing with load_valid held
    t_first = -1; t_second = -1;
    for (int j = 0; j < 20; j++) begin
      tick(1'b1, (j == 0) ? 4'hF : 4'h1, 1'b0, 1'b0);
      if (fs[1]) begin
        if (t_first < 0) t_first = j;
        else if (t_second < 0) t_second = j;
      end
    end
    chki("t3_spacing", t_second - t_first, 8);
    idle(10);

    // 4: abort on the 2nd bit, then immediate re-accept
    tick(1'b1, 4'hC, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    chk("t4_valid", 0, sv[0], 1'b0);
    chk("t4_busy",  0, bz[0], 1'b0);
    chk("t4_end",   0, fe[0], 1'b0);
    tick(1'b1, 4'h5, 1'b0, 1'b0);
    chk("t4_reaccept", 0, sv[0], 1'b1);
    idle(10);

    // 5: asynchronous reset mid-frame
    tick(1'b1, 4'hA, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    check_outs();
    check_ready();
    #3 reset_n = 1'b1;
    idle(2);

    // 6: single-bit frames, abort blocks accept in idle
    tick(1'b1, 4'h1, 1'b0, 1'b0);
    chk("t6_start", 2, fs[2], 1'b1);
    chk("t6_end",   2, fe[2], 1'b1);
    chk("t6_valid", 2, sv[2], 1'b1);
    tick(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t6_single", 2, sv[2], 1'b0);
    idle(10);
    tick(1'b1, 4'hF, 1'b0, 1'b1);
    chk("t6_abort_busy",  2, bz[2], 1'b0);
    chk("t6_abort_valid", 0, sv[0], 1'b0);
    idle(2);

    // random traffic
    for (int j = 0; j < 400; j++) begin
      tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 4'($urandom), 1'($urandom),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
